// File: rtl/seq_detect_param.sv
// Parameterized symbol-sequence detector with Mealy/Moore match flags,
// illegal-symbol error pulse and a saturating match counter.
module seq_detect_param #(
  parameter int W = 3,
  parameter int N = 4,
  parameter logic [N*W-1:0] PATTERN = {3'd1, 3'd2, 3'd1, 3'd2},
  parameter int MAX_SYM = 5,
  parameter int OVERLAP = 1,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             x_valid,
  input  logic [W-1:0]     x,
  output logic             z,
  output logic             z_reg,
  output logic             error,
  output logic [CNT_W-1:0] match_cnt
);

  generate
    if (N < 1 || W < 1 || CNT_W < 1 || MAX_SYM < 0 ||
        MAX_SYM >= (64'd1 << W)) begin : g_bad_params
      $error("seq_detect_param: illegal parameter combination");
    end
  endgenerate

  // History holds N-1 symbols; N=1 keeps a dummy word that stays zero.
  localparam int HW = (N > 1) ? (N - 1) * W : W;
  localparam int FW = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0]  MAX_V    = W'(MAX_SYM);
  localparam logic [FW-1:0] FILL_MAX = FW'(N - 1);

  logic [HW-1:0] hist;
  logic [HW-1:0] hist_nxt;
  logic [FW-1:0] fill;
  logic          accepted;
  logic          illegal;
  logic          hit;

  assign accepted = x_valid && (x <= MAX_V);
  assign illegal  = x_valid && (x > MAX_V);

  generate
    if (N == 1) begin : g_n1
      assign hit      = (x == PATTERN);
      assign hist_nxt = '0;
    end else if (N == 2) begin : g_n2
      assign hit      = ({hist, x} == PATTERN);
      assign hist_nxt = x;
    end else begin : g_nn
      assign hit      = ({hist, x} == PATTERN);
      assign hist_nxt = {hist[HW-W-1:0], x};
    end
  endgenerate

  assign z = !reset && accepted && (fill == FILL_MAX) && hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      hist      <= '0;
      fill      <= '0;
      z_reg     <= 1'b0;
      error     <= 1'b0;
      match_cnt <= '0;
    end else begin
      z_reg <= z;
      error <= illegal;
      if (illegal) begin
        fill <= '0;
      end else if (accepted) begin
        hist <= hist_nxt;
        if (z && OVERLAP == 0)
          fill <= '0;
        else if (fill != FILL_MAX)
          fill <= fill + FW'(1);
      end
      if (z && match_cnt != '1)
        match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Randomized bench for seq_detect_param: three configurations driven in
// lockstep and checked against a queue-based reference model.
module tb_seq_detect_param;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       x_valid = 1'b0;
  logic [2:0] x = '0;

  logic       z0, z1, z2;
  logic       zr0, zr1, zr2;
  logic       er0, er1, er2;
  logic [7:0] c0, c1;
  logic [1:0] c2;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  seq_detect_param u_ovl (
    .clock(clock), .reset(reset), .x_valid(x_valid), .x(x),
    .z(z0), .z_reg(zr0), .error(er0), .match_cnt(c0)
  );

  seq_detect_param #(.OVERLAP(0)) u_novl (
    .clock(clock), .reset(reset), .x_valid(x_valid), .x(x),
    .z(z1), .z_reg(zr1), .error(er1), .match_cnt(c1)
  );

  seq_detect_param #(.OVERLAP(0), .CNT_W(2)) u_sat (
    .clock(clock), .reset(reset), .x_valid(x_valid), .x(x),
    .z(z2), .z_reg(zr2), .error(er2), .match_cnt(c2)
  );

  // Reference model: log of accepted symbols since the last clear,
  // and per-instance start index after a non-overlapping match.
  int pat [4] = '{1, 2, 1, 2};
  int ovl [3] = '{1, 0, 0};
  int cmax [3] = '{255, 255, 3};
  int log_q [$];
  int base [3];
  int mz [3];
  int ezr [3];
  int eer;
  int ecnt [3];
  bit started = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_hit(input int k, input int xi);
    int n;
    n = log_q.size();
    if (n - base[k] < 3) return 0;
    for (int i = 0; i < 3; i++)
      if (log_q[n - 3 + i] != pat[i]) return 0;
    return (xi == pat[3]) ? 1 : 0;
  endfunction

  task automatic chk_regs();
    check("z_reg0", int'(zr0), ezr[0]);
    check("z_reg1", int'(zr1), ezr[1]);
    check("z_reg2", int'(zr2), ezr[2]);
    check("error0", int'(er0), eer);
    check("error1", int'(er1), eer);
    check("error2", int'(er2), eer);
    check("cnt0", int'(c0), ecnt[0]);
    check("cnt1", int'(c1), ecnt[1]);
    check("cnt2", int'(c2), ecnt[2]);
  endtask

  task automatic step(input logic v, input int xi, input logic rst);
    bit acc, ill;
    @(negedge clock);
    if (started) chk_regs();
    x_valid = v;
    x = 3'(xi);
    reset = rst;
    #1;
    acc = v && xi <= 5;
    ill = v && xi > 5;
    for (int k = 0; k < 3; k++)
      mz[k] = (!rst && acc) ? model_hit(k, xi) : 0;
    check("z0", int'(z0), mz[0]);
    check("z1", int'(z1), mz[1]);
    check("z2", int'(z2), mz[2]);
    @(posedge clock);
    started = 1;
    if (rst) begin
      log_q.delete();
      eer = 0;
      for (int k = 0; k < 3; k++) begin
        base[k] = 0;
        ezr[k] = 0;
        ecnt[k] = 0;
      end
    end else begin
      eer = ill ? 1 : 0;
      for (int k = 0; k < 3; k++) begin
        ezr[k] = mz[k];
        if (mz[k] != 0 && ecnt[k] < cmax[k]) ecnt[k]++;
      end
      if (ill) begin
        log_q.delete();
        for (int k = 0; k < 3; k++) base[k] = 0;
      end else if (acc) begin
        log_q.push_back(xi);
        for (int k = 0; k < 3; k++)
          if (mz[k] != 0 && ovl[k] == 0) base[k] = log_q.size();
      end
    end
  endtask

  task automatic sym(input int xi);
    step(1'b1, xi, 1'b0);
  endtask

  initial begin
    int exp_sat [5] = '{1, 2, 3, 3, 3};
    int r;
    step(1'b0, 0, 1'b1);
    step(1'b1, 1, 1'b1);
    // Basic match: 1,2,1,2
    sym(1); sym(2); sym(1); sym(2);
    step(1'b0, 3, 1'b0);
    check("basic_cnt", int'(c0), 1);
    // Overlap vs non-overlap: 1,2,1,2,1,2
    step(1'b0, 0, 1'b1);
    sym(1); sym(2); sym(1); sym(2); sym(1); sym(2);
    step(1'b0, 0, 1'b0);
    check("ovl_cnt", int'(c0), 2);
    check("novl_cnt", int'(c1), 1);
    // Illegal symbol breaks a prefix
    step(1'b0, 0, 1'b1);
    sym(1); sym(2); sym(6);
    step(1'b1, 1, 1'b0);
    check("err_pulse", int'(er0), 1);
    sym(2); sym(1); sym(2);
    step(1'b0, 0, 1'b0);
    check("illegal_cnt", int'(c0), 1);
    // Gap with x_valid low
    step(1'b0, 0, 1'b1);
    sym(1); sym(2);
    step(1'b0, 3, 1'b0);
    step(1'b0, 3, 1'b0);
    sym(1); sym(2);
    step(1'b0, 0, 1'b0);
    check("gap_cnt", int'(c0), 1);
    // Reset discards a partial prefix
    step(1'b0, 0, 1'b1);
    sym(1); sym(2); sym(1);
    step(1'b1, 2, 1'b1);
    sym(2);
    step(1'b0, 0, 1'b0);
    check("rst_prefix_cnt", int'(c0), 0);
    // Saturating counter on CNT_W=2
    step(1'b0, 0, 1'b1);
    for (int m = 0; m < 5; m++) begin
      sym(1); sym(2); sym(1); sym(2);
      step(1'b0, 0, 1'b0);
      check("sat_cnt", int'(c2), exp_sat[m]);
    end
    // Randomized traffic biased toward the pattern symbols
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 49);
      if (r == 0)
        step(1'b1, int'($urandom_range(0, 7)), 1'b1);
      else if (r < 18)
        sym(1);
      else if (r < 33)
        sym(2);
      else if (r < 42)
        sym(int'($urandom_range(0, 7)));
      else
        step(1'b0, int'($urandom_range(0, 7)), 1'b0);
    end
    step(1'b0, 0, 1'b0);
    @(negedge clock);
    chk_regs();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter W, default 3, symbol width in bits (W >= 1).
REQ-002 SHALL have parameter N, default 4, pattern length in symbols (N >= 1).
REQ-003 SHALL have parameter PATTERN, default {3'd1,3'd2,3'd1,3'd2}, N*W bits; bits [N*W-1 -: W] are the first (oldest) symbol.
REQ-004 SHALL have parameter MAX_SYM, default 5, the largest legal symbol value (MAX_SYM < 2**W).
REQ-005 SHALL have parameter OVERLAP, default 1: 1 = overlapping matches, 0 = history cleared after a match.
REQ-006 SHALL have parameter CNT_W, default 8, match counter width.
REQ-007 clock  input  1  single clock; all state on rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 x_valid  input  1  x carries a symbol this cycle.
REQ-010 x  input  W  input symbol.
REQ-011 z  output  1  Mealy match flag, combinational, same cycle as the final symbol.
REQ-012 z_reg  output  1  Moore match flag, z registered (1-cycle latency).
REQ-013 error  output  1  registered one-cycle pulse for an illegal symbol.
REQ-014 match_cnt  output  CNT_W  saturating count of matches since reset.

Function
REQ-015 Accepted symbol SHALL mean x_valid=1 and x <= MAX_SYM; illegal symbol SHALL mean x_valid=1 and x > MAX_SYM.
REQ-016 Block SHALL hold a history of the last N-1 accepted symbols and a fill count 0..N-1 of valid history entries.
REQ-017 z SHALL be 1 iff reset=0, the symbol is accepted, fill = N-1, and {history, x} equals PATTERN (N=1: x equals PATTERN).
REQ-018 On an accepted symbol, x SHALL shift into the history and fill SHALL increment, saturating at N-1.
REQ-019 With OVERLAP=0 and z=1, fill SHALL become 0 at the next edge (the next match needs N fresh symbols).
REQ-020 On an illegal symbol, z SHALL be 0, fill SHALL become 0, and error SHALL be 1 in the following cycle only.
REQ-021 With x_valid=0, history, fill and match_cnt SHALL hold; z=0; z_reg and error SHALL be 0 in the following cycle.
REQ-022 z_reg SHALL equal the value z had in the previous cycle.
REQ-023 match_cnt SHALL increment by 1 on every cycle with z=1 and SHALL saturate at 2**CNT_W-1, with no wrap.
REQ-024 x bits SHALL be compared exactly; no don't-care symbols.
REQ-025 Illegal parameter combinations (N<1, W<1, MAX_SYM >= 2**W, CNT_W<1) SHALL stop elaboration with an error.

Reset
REQ-026 With reset=1 at an edge, fill SHALL be 0, history SHALL be all zero, and z_reg, error and match_cnt SHALL be 0 after that edge.
REQ-027 While reset=1, z SHALL be 0 regardless of x and x_valid.
REQ-028 Reset SHALL take priority over every simultaneous input event.
REQ-029 A partial prefix in progress when reset is asserted SHALL be discarded.
REQ-030 After reset the block SHALL require N accepted symbols before a match is possible.

Verification
REQ-031 Defaults, reset, then x = 1,2,1,2 on consecutive cycles -> z=1 in the cycle of the 4th symbol, z_reg=1 one cycle later, match_cnt=1.
REQ-032 Stream 1,2,1,2,1,2 -> OVERLAP=1: z on symbols 4 and 6, match_cnt=2; OVERLAP=0: z on symbol 4 only, match_cnt=1.
REQ-033 Stream 1,2,6,1,2,1,2 -> error=1 exactly in the cycle after the 6, no z from the first pair, z on the last symbol, match_cnt=1.
REQ-034 Stream 1,2, two cycles with x_valid=0 (x=3), then 1,2 -> z=1 on the final 2; z=0 and error=0 during the gap.
REQ-035 Stream 1,2,1, reset for one cycle, then 2 -> z=0 and match_cnt=0 afterwards.
REQ-036 CNT_W=2, five non-overlapping matches of 1,2,1,2 -> match_cnt reads 1,2,3,3,3.
